// File: rtl/reg_ctrl_seq_pkg.sv
// Shared definitions for the register-transfer micro-op sequencer:
// opcode constants, default sizes, FSM state encoding and a sizing helper.
package reg_ctrl_seq_pkg;

  localparam int NUM_REGS_DEF = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int CNT_W_DEF    = 4;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_LDI  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_INCN = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_INC   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Register index width; a single-register bank still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_ctrl_seq_if.sv
// Micro-op handshake and register-bank strobe bundle between the op source
// (master) and the sequencer (slave).
interface reg_ctrl_seq_if #(
  parameter int NUM_REGS = reg_ctrl_seq_pkg::NUM_REGS_DEF,
  parameter int DATA_W   = reg_ctrl_seq_pkg::DATA_W_DEF
);
  import reg_ctrl_seq_pkg::*;

  localparam int IDX_W = idx_width(NUM_REGS);

  logic                op_valid;
  logic                op_ready;
  logic [2:0]          op_code;
  logic [IDX_W-1:0]    op_src;
  logic [IDX_W-1:0]    op_dst;
  logic [DATA_W-1:0]   op_imm;
  logic [NUM_REGS-1:0] wr_en;
  logic [NUM_REGS-1:0] ldbus_en;
  logic [NUM_REGS-1:0] inc_en;
  logic                imm_en;
  logic [DATA_W-1:0]   bus_imm;
  logic                op_done;
  logic                op_err;

  modport master (
    output op_valid, op_code, op_src, op_dst, op_imm,
    input  op_ready, wr_en, ldbus_en, inc_en, imm_en, bus_imm, op_done, op_err
  );

  modport slave (
    input  op_valid, op_code, op_src, op_dst, op_imm,
    output op_ready, wr_en, ldbus_en, inc_en, imm_en, bus_imm, op_done, op_err
  );

endinterface

// File: rtl/reg_ctrl_seq_onehot_dec.sv
// Register index to one-hot strobe decoder; flags indices beyond the bank.
module onehot_dec #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot,
  output logic                oor
);

  // Match the index against every implemented register; no match means out of range.
  always_comb begin
    onehot = {NUM_REGS{1'b0}};
    oor    = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) begin
        onehot[i] = 1'b1;
        oor       = 1'b0;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_ctrl_seq.sv
// Micro-op sequencer: expands one accepted register-transfer op into
// cycle-by-cycle one-hot WR/LDBUS/INC strobes and an immediate bus drive.
// Every output is registered from the next-state values, so the strobes of a
// state appear in the cycle the FSM occupies that state.
module reg_ctrl_seq
  import reg_ctrl_seq_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic           clk,
  input logic           RST,
  reg_ctrl_seq_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REGS);

  state_t              state_r, state_nx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
  logic [2:0]          code_r, code_nx_s;
  logic [IDX_W-1:0]    src_r, src_nx_s;
  logic [IDX_W-1:0]    dst_r, dst_nx_s;
  logic                err_r, err_nx_s;

  logic                op_ready_r;
  logic [NUM_REGS-1:0] wr_en_r, ldbus_en_r, inc_en_r;
  logic                imm_en_r;
  logic [DATA_W-1:0]   bus_imm_r;
  logic                op_done_r, op_err_r;

  logic [NUM_REGS-1:0] wr_en_nx_s, ldbus_en_nx_s, inc_en_nx_s;
  logic                imm_en_nx_s;
  logic [DATA_W-1:0]   bus_imm_nx_s;

  logic                accept_s;
  logic                acc_err_s;
  logic [IDX_W-1:0]    src_sel_s, dst_sel_s;
  logic [NUM_REGS-1:0] src_oh_s, dst_oh_s;
  logic                src_oor_s, dst_oor_s;

  assign accept_s = bus.op_valid & op_ready_r;

  // On the accept cycle decode the incoming fields, otherwise the latched ones.
  assign src_sel_s = accept_s ? bus.op_src : src_r;
  assign dst_sel_s = accept_s ? bus.op_dst : dst_r;

  onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_src_dec (
    .idx    (src_sel_s),
    .onehot (src_oh_s),
    .oor    (src_oor_s)
  );

  onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dst_dec (
    .idx    (dst_sel_s),
    .onehot (dst_oh_s),
    .oor    (dst_oor_s)
  );

  // Classify the op being accepted: illegal opcode or a bad register index is an error.
  always_comb begin
    acc_err_s = 1'b0;
    case (bus.op_code)
      OP_NOP:                  acc_err_s = 1'b0;
      OP_MOV:                  acc_err_s = src_oor_s | dst_oor_s;
      OP_LDI, OP_INC, OP_INCN: acc_err_s = dst_oor_s;
      default:                 acc_err_s = 1'b1;
    endcase
  end

  // Next-state, counter and field-latch logic.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    code_nx_s  = code_r;
    src_nx_s   = src_r;
    dst_nx_s   = dst_r;
    err_nx_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          code_nx_s = bus.op_code;
          src_nx_s  = bus.op_src;
          dst_nx_s  = bus.op_dst;
          err_nx_s  = acc_err_s;
          cnt_nx_s  = {CNT_W{1'b0}};
          if (acc_err_s) begin
            state_nx_s = ST_DONE;
          end else begin
            case (bus.op_code)
              OP_MOV:  state_nx_s = ST_READ;
              OP_LDI:  state_nx_s = ST_WRITE;
              OP_INC: begin
                cnt_nx_s   = CNT_W'(1);
                state_nx_s = ST_INC;
              end
              OP_INCN: begin
                cnt_nx_s   = bus.op_imm[CNT_W-1:0];
                state_nx_s = (bus.op_imm[CNT_W-1:0] == {CNT_W{1'b0}}) ? ST_DONE : ST_INC;
              end
              default: state_nx_s = ST_DONE;
            endcase
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_READ:  state_nx_s = ST_WRITE;
      ST_WRITE: state_nx_s = ST_DONE;
      ST_INC: begin
        if (cnt_r > CNT_W'(1)) begin
          cnt_nx_s   = cnt_r - CNT_W'(1);
          state_nx_s = ST_INC;
        end else if (cnt_r == CNT_W'(1)) begin
          // INCN spends one trailing strobe-free INC cycle before completing.
          cnt_nx_s   = {CNT_W{1'b0}};
          state_nx_s = (code_r == OP_INCN) ? ST_INC : ST_DONE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Strobe values for the state being entered; they are registered below.
  always_comb begin
    wr_en_nx_s    = {NUM_REGS{1'b0}};
    ldbus_en_nx_s = {NUM_REGS{1'b0}};
    inc_en_nx_s   = {NUM_REGS{1'b0}};
    imm_en_nx_s   = 1'b0;
    bus_imm_nx_s  = bus_imm_r;
    case (state_nx_s)
      ST_READ: ldbus_en_nx_s = src_oh_s;
      ST_WRITE: begin
        wr_en_nx_s  = dst_oh_s;
        imm_en_nx_s = (code_nx_s == OP_LDI);
      end
      ST_INC: begin
        if (cnt_nx_s != {CNT_W{1'b0}}) begin
          inc_en_nx_s = dst_oh_s;
        end else begin
          inc_en_nx_s = {NUM_REGS{1'b0}};
        end
      end
      default: wr_en_nx_s = {NUM_REGS{1'b0}};
    endcase
    // The immediate stays on bus_imm until the next executed LDI.
    if (accept_s && !acc_err_s && bus.op_code == OP_LDI) begin
      bus_imm_nx_s = bus.op_imm;
    end else begin
      bus_imm_nx_s = bus_imm_r;
    end
  end

  // State, latched op fields and registered outputs; RST aborts any op in flight.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      code_r     <= OP_NOP;
      src_r      <= {IDX_W{1'b0}};
      dst_r      <= {IDX_W{1'b0}};
      err_r      <= 1'b0;
      op_ready_r <= 1'b0;
      wr_en_r    <= {NUM_REGS{1'b0}};
      ldbus_en_r <= {NUM_REGS{1'b0}};
      inc_en_r   <= {NUM_REGS{1'b0}};
      imm_en_r   <= 1'b0;
      bus_imm_r  <= {DATA_W{1'b0}};
      op_done_r  <= 1'b0;
      op_err_r   <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      code_r     <= code_nx_s;
      src_r      <= src_nx_s;
      dst_r      <= dst_nx_s;
      err_r      <= err_nx_s;
      op_ready_r <= (state_nx_s == ST_IDLE);
      wr_en_r    <= wr_en_nx_s;
      ldbus_en_r <= ldbus_en_nx_s;
      inc_en_r   <= inc_en_nx_s;
      imm_en_r   <= imm_en_nx_s;
      bus_imm_r  <= bus_imm_nx_s;
      op_done_r  <= (state_nx_s == ST_DONE);
      op_err_r   <= (state_nx_s == ST_DONE) & err_nx_s;
    end
  end

  assign bus.op_ready = op_ready_r;
  assign bus.wr_en    = wr_en_r;
  assign bus.ldbus_en = ldbus_en_r;
  assign bus.inc_en   = inc_en_r;
  assign bus.imm_en   = imm_en_r;
  assign bus.bus_imm  = bus_imm_r;
  assign bus.op_done  = op_done_r;
  assign bus.op_err   = op_err_r;

endmodule

// File: tb/tb_reg_ctrl_seq.sv
// Directed, table-driven bench for reg_ctrl_seq with a behavioural register bank.
module tb_reg_ctrl_seq;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] regs [8];
  logic [15:0] bus_q;

  typedef struct {
    logic [2:0]  code;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [15:0] imm;
    int          lat;    // accept edge to op_done, in cycles
    logic [7:0]  ld1;    // ldbus_en in cycle 1
    logic [7:0]  wr1;    // wr_en in cycle 1
    logic [7:0]  wr2;    // wr_en in cycle 2
    logic [7:0]  inc_v;  // inc_en in cycles 1..n_inc
    int          n_inc;
    logic        imm1;   // imm_en in cycle 1
    logic        err;    // op_err with op_done
    logic [15:0] bimm;   // bus_imm throughout the op
  } vec_t;

  vec_t vecs [12];
  vec_t post_vec;

  reg_ctrl_seq_if #(.NUM_REGS(8), .DATA_W(16)) ifc ();

  reg_ctrl_seq #(.NUM_REGS(8), .DATA_W(16), .CNT_W(4)) dut (
    .clk (clk),
    .RST (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic [2:0] code, input logic [2:0] src, input logic [2:0] dst,
                              input logic [15:0] imm, input int lat, input logic [7:0] ld1,
                              input logic [7:0] wr1, input logic [7:0] wr2, input logic [7:0] inc_v,
                              input int n_inc, input logic imm1, input logic err, input logic [15:0] bimm);
    vec_t v;
    v.code = code; v.src = src; v.dst = dst; v.imm = imm; v.lat = lat;
    v.ld1 = ld1; v.wr1 = wr1; v.wr2 = wr2; v.inc_v = inc_v; v.n_inc = n_inc;
    v.imm1 = imm1; v.err = err; v.bimm = bimm;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Register bank model: LDBUS latches a register onto the bus, WR loads the
  // bus (or the immediate when imm_en), INC adds one.
  task automatic model_update();
    for (int r = 0; r < 8; r++) begin
      if (ifc.ldbus_en[r] === 1'b1) bus_q = regs[r];
    end
    for (int r = 0; r < 8; r++) begin
      if (ifc.wr_en[r] === 1'b1) regs[r] = (ifc.imm_en === 1'b1) ? ifc.bus_imm : bus_q;
      if (ifc.inc_en[r] === 1'b1) regs[r] = regs[r] + 16'd1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " wr_en"},    32'(ifc.wr_en),    32'd0);
    check({tag, " ldbus_en"}, 32'(ifc.ldbus_en), 32'd0);
    check({tag, " inc_en"},   32'(ifc.inc_en),   32'd0);
    check({tag, " imm_en"},   32'(ifc.imm_en),   32'd0);
    check({tag, " op_done"},  32'(ifc.op_done),  32'd0);
    check({tag, " op_err"},   32'(ifc.op_err),   32'd0);
  endtask

  // Called at a negedge; issues one op and checks every cycle through the first idle cycle.
  task automatic run_vec(input int id, input vec_t v);
    int guard = 0;
    logic [7:0] e_ld, e_wr, e_inc;
    while (ifc.op_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("v%0d op_ready before accept", id), 32'(ifc.op_ready), 32'd1);
    ifc.op_valid = 1'b1;
    ifc.op_code  = v.code;
    ifc.op_src   = v.src;
    ifc.op_dst   = v.dst;
    ifc.op_imm   = v.imm;
    @(posedge clk);
    #1;
    ifc.op_valid = 1'b0;
    ifc.op_code  = 3'd2;
    ifc.op_src   = 3'd7;
    ifc.op_dst   = 3'd6;
    ifc.op_imm   = 16'h1234;
    for (int c = 1; c <= v.lat + 1; c++) begin
      @(negedge clk);
      e_ld  = (c == 1) ? v.ld1 : 8'd0;
      e_wr  = (c == 1) ? v.wr1 : ((c == 2) ? v.wr2 : 8'd0);
      e_inc = (c <= v.n_inc) ? v.inc_v : 8'd0;
      check($sformatf("v%0d c%0d ldbus_en", id, c), 32'(ifc.ldbus_en), 32'(e_ld));
      check($sformatf("v%0d c%0d wr_en", id, c),    32'(ifc.wr_en),    32'(e_wr));
      check($sformatf("v%0d c%0d inc_en", id, c),   32'(ifc.inc_en),   32'(e_inc));
      check($sformatf("v%0d c%0d imm_en", id, c),   32'(ifc.imm_en),   32'((c == 1) ? v.imm1 : 1'b0));
      check($sformatf("v%0d c%0d bus_imm", id, c),  32'(ifc.bus_imm),  32'(v.bimm));
      check($sformatf("v%0d c%0d op_done", id, c),  32'(ifc.op_done),  32'(c == v.lat));
      check($sformatf("v%0d c%0d op_err", id, c),   32'(ifc.op_err),   32'((c == v.lat) ? v.err : 1'b0));
      check($sformatf("v%0d c%0d op_ready", id, c), 32'(ifc.op_ready), 32'(c == v.lat + 1));
      model_update();
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) regs[r] = 16'd0;
    bus_q = 16'd0;

    //          code  src   dst   imm       lat ld1     wr1     wr2     inc_v   n  imm1  err   bimm
    vecs[0]  = mk(3'd2, 3'd0, 3'd2, 16'd35,    2, 8'h00, 8'h04, 8'h00, 8'h00, 0, 1'b1, 1'b0, 16'd35);
    vecs[1]  = mk(3'd1, 3'd2, 3'd5, 16'd0,     3, 8'h04, 8'h00, 8'h20, 8'h00, 0, 1'b0, 1'b0, 16'd35);
    vecs[2]  = mk(3'd0, 3'd0, 3'd0, 16'hFFFF,  1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0, 16'd35);
    vecs[3]  = mk(3'd3, 3'd0, 3'd7, 16'd9,     2, 8'h00, 8'h00, 8'h00, 8'h80, 1, 1'b0, 1'b0, 16'd35);
    vecs[4]  = mk(3'd4, 3'd0, 3'd2, 16'd3,     5, 8'h00, 8'h00, 8'h00, 8'h04, 3, 1'b0, 1'b0, 16'd35);
    vecs[5]  = mk(3'd4, 3'd0, 3'd4, 16'd0,     1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0, 16'd35);
    vecs[6]  = mk(3'd6, 3'd1, 3'd2, 16'h0055,  1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 16'd35);
    vecs[7]  = mk(3'd1, 3'd3, 3'd3, 16'd0,     3, 8'h08, 8'h00, 8'h08, 8'h00, 0, 1'b0, 1'b0, 16'd35);
    vecs[8]  = mk(3'd2, 3'd0, 3'd0, 16'hBEEF,  2, 8'h00, 8'h01, 8'h00, 8'h00, 0, 1'b1, 1'b0, 16'hBEEF);
    vecs[9]  = mk(3'd7, 3'd0, 3'd1, 16'd0,     1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 16'hBEEF);
    vecs[10] = mk(3'd4, 3'd0, 3'd1, 16'hFFF2,  4, 8'h00, 8'h00, 8'h00, 8'h02, 2, 1'b0, 1'b0, 16'hBEEF);
    vecs[11] = mk(3'd4, 3'd0, 3'd6, 16'd15,   17, 8'h00, 8'h00, 8'h00, 8'h40, 15, 1'b0, 1'b0, 16'hBEEF);
    post_vec = mk(3'd2, 3'd0, 3'd4, 16'h0A5A,  2, 8'h00, 8'h10, 8'h00, 8'h00, 0, 1'b1, 1'b0, 16'h0A5A);

    // Reset held for two cycles with no op offered.
    rst          = 1'b1;
    ifc.op_valid = 1'b0;
    ifc.op_code  = 3'd0;
    ifc.op_src   = 3'd0;
    ifc.op_dst   = 3'd0;
    ifc.op_imm   = 16'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_idle_outputs($sformatf("reset c%0d", c));
      check($sformatf("reset c%0d op_ready", c), 32'(ifc.op_ready), 32'd0);
      check($sformatf("reset c%0d bus_imm", c),  32'(ifc.bus_imm),  32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post-reset op_ready", 32'(ifc.op_ready), 32'd1);
    check_idle_outputs("post-reset");

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // INCN 15 on R2, aborted by RST after four pulses.
    ifc.op_valid = 1'b1;
    ifc.op_code  = 3'd4;
    ifc.op_src   = 3'd0;
    ifc.op_dst   = 3'd2;
    ifc.op_imm   = 16'd15;
    @(posedge clk);
    #1;
    ifc.op_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("abort c%0d inc_en", c),  32'(ifc.inc_en),  32'h04);
      check($sformatf("abort c%0d op_done", c), 32'(ifc.op_done), 32'd0);
      model_update();
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort reset");
    check("abort reset op_ready", 32'(ifc.op_ready), 32'd0);
    check("abort reset bus_imm",  32'(ifc.bus_imm),  32'd0);
    model_update();
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check_idle_outputs($sformatf("after abort c%0d", c));
      check($sformatf("after abort c%0d op_ready", c), 32'(ifc.op_ready), 32'd1);
      model_update();
    end

    run_vec(12, post_vec);

    // Register bank contents produced by the strobes the DUT issued.
    check("R0 after LDI",        32'(regs[0]), 32'h0000BEEF);
    check("R1 after INCN 2",     32'(regs[1]), 32'd2);
    check("R2 after LDI/INCN",   32'(regs[2]), 32'd42);
    check("R3 after MOV self",   32'(regs[3]), 32'd0);
    check("R4 after post LDI",   32'(regs[4]), 32'h00000A5A);
    check("R5 after MOV",        32'(regs[5]), 32'd35);
    check("R6 after INCN 15",    32'(regs[6]), 32'd15);
    check("R7 after INC",        32'(regs[7]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_ctrl_seq.md
Name: reg_ctrl_seq

Overview:
- Micro-op sequencer that sits directly upstream of the general-purpose register bank (R1..Rn, including R2).
- Accepts one register-transfer micro-op per handshake and expands it into cycle-by-cycle one-hot WR/LDBUS/INC strobes, plus an immediate-drive path onto the shared 16-bit bus.
- Owns bus sequencing only. Registers and the bus mux are external.

Parameters:
- NUM_REGS, 8, number of registers controlled; index width is clog2(NUM_REGS).
- DATA_W, 16, bus/immediate width.
- CNT_W, 4, width of repeat count for INCN.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- op_valid  in  1  micro-op present.
- op_ready  out  1  sequencer can accept a micro-op.
- op_code  in  3  0 NOP, 1 MOV, 2 LDI, 3 INC, 4 INCN, 5-7 illegal.
- op_src  in  clog2(NUM_REGS)  source register index (MOV).
- op_dst  in  clog2(NUM_REGS)  destination register index.
- op_imm  in  DATA_W  immediate (LDI) / repeat count in [CNT_W-1:0] (INCN).
- wr_en  out  NUM_REGS  one-hot register WR strobes.
- ldbus_en  out  NUM_REGS  one-hot register LDBUS strobes.
- inc_en  out  NUM_REGS  one-hot register INC strobes.
- imm_en  out  1  sequencer drives bus_imm onto the bus this cycle.
- bus_imm  out  DATA_W  immediate value for the bus mux.
- op_done  out  1  one-cycle pulse: micro-op completed.
- op_err  out  1  one-cycle pulse, concurrent with op_done, for an illegal opcode.

Behaviour:
- All outputs registered. On RST: state IDLE; wr_en, ldbus_en and inc_en = 0; imm_en = 0; bus_imm = 0; op_done = 0; op_err = 0; op_ready = 0 during the reset cycle, then 1 in IDLE.
- RST asserted mid-operation aborts it: all strobes are 0 after the next edge and no op_done is issued.
- op_ready = 1 only in IDLE. Accept occurs on op_valid & op_ready. op_code/src/dst/imm are latched at accept; inputs are don't-care afterwards.
- At most one bit is set across each strobe vector per cycle. At most one of {wr_en, ldbus_en, inc_en, imm_en} classes targets a given register in a cycle.
- States: IDLE, READ, WRITE, INC, DONE.
- NOP: IDLE -> DONE (no strobes) -> IDLE.
- MOV: READ (ldbus_en[src] = 1) -> WRITE (wr_en[dst] = 1) -> DONE. src == dst is legal and executed identically.
- LDI: WRITE (imm_en = 1, bus_imm = op_imm, wr_en[dst] = 1) -> DONE. bus_imm holds its value until the next LDI or RST.
- INC: INC (inc_en[dst] = 1 for one cycle) -> DONE.
- INCN: counter loaded with op_imm[CNT_W-1:0]. Stay in INC with inc_en[dst] = 1 for exactly N consecutive cycles, then DONE. N = 0 goes straight to DONE with no strobes. N = 15 gives 15 pulses; the counter never wraps.
- Illegal opcode (5-7): DONE with op_err = 1, no strobes.
- DONE: op_done = 1 for one cycle, then IDLE.
- Latency from accept edge to op_done: NOP 1, LDI 2, INC 2, MOV 3, INCN N+2 (N=0: 1).
- Back-to-back ops: a new accept is possible the cycle after DONE. Minimum spacing = latency + 1.
- Register index >= NUM_REGS (non-power-of-2 NUM_REGS): no strobe is asserted, op_err = 1 at DONE.

Decomposition:
- Shared package holds the opcode constants (OP_NOP..OP_INCN), DATA_W default, and the state encoding enum.
- One natural sub-module: onehot_dec (index -> one-hot NUM_REGS with an out-of-range flag), instantiated for src and dst.
- Counter and FSM stay in the top module.

Test Plan:
- RST = 1 for 2 cycles, op_valid = 0 -> all strobes 0, op_ready = 1 the cycle after RST drops.
- LDI dst = 2, imm = 35 -> next cycle wr_en = 8'b0000_0100, imm_en = 1, bus_imm = 35; following cycle op_done = 1; then op_ready = 1.
- MOV src = 2, dst = 5 -> ldbus_en = 8'b0000_0100 for one cycle, then wr_en = 8'b0010_0000, then op_done; with a behavioural register model, R5 = 35.
- INCN dst = 2, count = 3 -> inc_en[2] high exactly 3 consecutive cycles, op_done at accept + 5. INCN count = 0 -> no inc_en, op_done at accept + 1.
- op_code = 6 -> no strobes, op_done = op_err = 1 at accept + 1.
- INCN count = 15, RST asserted after 4 pulses -> strobes 0 after the next edge, no op_done, next LDI executes normally.
